exec_stage_mc: RTL and testbench
================================

Name: exec_stage_mc

Overview:
- Parametrised execute stage for the pipelined ARM core. It sits between the decode and memory pipeline registers.
- Contains the D→E pipeline register, operand forwarding muxes, an immediate barrel shifter, the ALU, the NZCV flag register and condition check.
- Adds a multicycle iterative MUL/MLA unit that holds the stage and raises a stall to the hazard unit.
- Generalised in datapath width, register-address width and multiplier radix.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of 2, ≥8.
- RA_W, 4, register address width.
- MUL_RADIX, 2, product bits retired per multiply iteration (1, 2 or 4); N = WIDTH/MUL_RADIX.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous bubble insert into E.
- valid_d  in  1  decode stage holds a real instruction.
- regwrite_d, memwrite_d, memtoreg_d, branch_d, alusrc_d  in  1 each  decoded controls.
- alucontrol_d  in  4  operation code.
- flagwrite_d  in  2  bit1 = NZ write, bit0 = CV write.
- cond_d  in  4  ARM condition field.
- sh_d  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- shamt_d  in  5  shift amount (log2 WIDTH LSBs used).
- rd_d, ra1_d, ra2_d  in  RA_W each  destination and source register addresses.
- rd1_d, rd2_d, acc_d, ext_d  in  WIDTH each  source operands, MLA accumulator, extended immediate.
- forward_a, forward_b  in  2 each  operand select: 00 register, 01 result_w, 10 alu_result_m, 11 register.
- result_w, alu_result_m  in  WIDTH each  forwarded values.
- busy  out  1  E occupied by an unfinished multiply; stall F/D.
- valid_e  out  1  E holds a completing instruction this cycle.
- regwrite_e, memwrite_e, memtoreg_e  out  1 each  gated controls to M.
- pcsrc_e, branch_taken_e  out  1 each  redirect signals.
- rd_e, ra1_e, ra2_e  out  RA_W each  for the hazard unit.
- alu_result_e, write_data_e  out  WIDTH each  result and store data.
- flags  out  4  registered NZCV.

Behaviour:
- Reset (reset==0 at a clk edge):
  - E register cleared, so valid_e=0 and every control output is 0.
  - All address and data outputs are 0.
  - flags=0000, multiply counter=0, busy=0.
  - Reset has priority over flush and busy.
- E register load: at a clk edge with busy==0, E captures all *_d inputs. valid_e follows valid_d.
- Flush: with busy==0, flush loads a bubble (valid=0, all enables 0). With busy==1, flush aborts the multiply: counter=0, bubble loaded, flags unchanged.
- Hold: with busy==1 and no flush, E and the operand latches hold and all *_d inputs are ignored. Upstream must keep D stable.
- Operands:
  - opA = fwd(rd1).
  - fwdB = fwd(rd2).
  - opB = alusrc ? ext : shift(fwdB, sh, shamt).
  - write_data_e = fwdB, unshifted.
  - A shift amount of 0 is identity for all four shift types.
  - ASR fills with the sign bit. ROR rotates.
- ALU codes:
  - 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR.
  - 0101 BIC (A&~B), 0110 MOV (B), 0111 MVN (~B).
  - 1000 ADC, 1001 SBC (A−B−!C).
  - 1010 MUL, 1011 MLA.
  - Other codes give result 0 with no flag change.
  - Results are truncated to WIDTH bits.
- Flag calculation:
  - N = result MSB; Z = (result==0).
  - Add/sub: C = carry out, with SUB/SBC C = no-borrow; V = signed overflow.
  - Logical/move ops and MUL/MLA: C and V are unchanged.
- Single-cycle ops: complete in the first E cycle. Outputs are combinational from the E register in that cycle.
- Multiply FSM, states IDLE and RUN:
  - IDLE: a MUL/MLA enters E with valid=1. In its first E cycle, latch opA, opB and (for MLA) acc_d as the initial accumulator; acc=0 for MUL. Go to RUN with counter=0 and busy=1.
  - RUN: each cycle, add (multiplicand × MUL_RADIX multiplier bits) shifted into place, then increment the counter.
  - Exit: after N iterations, return to IDLE and deassert busy. The result (acc + A×B low WIDTH bits) is presented that cycle.
  - Occupancy: a multiply holds E for N+1 cycles. busy is high for the first N of them.
  - A multiply with valid=0 never starts the FSM.
- Gating: while busy==1, valid_e, regwrite_e, memwrite_e, pcsrc_e and branch_taken_e are forced to 0. Only the completion cycle produces side effects.
- Condition check:
  - Evaluated against registered flags in the completion cycle, using the ARM table.
  - 1110 = always; 1111 = never.
  - If the condition fails, regwrite_e, memwrite_e, pcsrc_e and branch_taken_e are 0 and flags are not written. valid_e is still 1.
  - pcsrc_e = pcsrc&pass; branch_taken_e = branch&pass.
- Flag write: at the end of the completion cycle, if pass, apply flagwrite bits. Instructions behind see the new flags next cycle.
- Forwarding is honoured in every cycle E is not busy. The multiplier uses only operands latched at entry.

Test Plan:
- reset=0 for 2 cycles with random inputs → all outputs 0, flags=0000, busy=0. After release, ADD 5+7 with flagwrite=11 → alu_result_e=12, flags=0000.
- SUB 3−3 with flagwrite=11, then an ADD with cond=0000 (EQ) of 1+1 and regwrite=1 → flags become 0110 (Z,C). The EQ ADD has regwrite_e=1 and result 2. The same op with cond=0001 (NE) gives regwrite_e=0.
- forward_a=10 with alu_result_m=0x10, forward_b=01 with result_w=0x3, sh=LSL, shamt=2, ADD → alu_result_e=0x1C, write_data_e=0x3.
- WIDTH=32, MUL_RADIX=2, MUL 0xFFFF_FFFF×3 → busy high for 16 cycles with regwrite_e=0. Result 0xFFFF_FFFD on cycle 17 with regwrite_e=1. D inputs changed mid-run are ignored.
- MLA 6×7+100 with flagwrite=10 → result 142. N and Z update; C and V are preserved.
- flush asserted at busy cycle 5 of a MUL → the next cycle has busy=0, valid_e=0, flags unchanged. The following ADD executes normally. reset=0 mid-multiply likewise clears everything.

Source files
------------

// File: rtl/exec_stage_mc_if.sv
// Bus between decode/forwarding logic and the execute stage (D-side inputs, E-side outputs).
// Clock and reset stay as plain ports on the stage.
interface exec_stage_mc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = 4
);
  logic             flush;
  logic             valid_d, regwrite_d, memwrite_d, memtoreg_d, branch_d, alusrc_d;
  logic [3:0]       alucontrol_d;
  logic [1:0]       flagwrite_d;
  logic [3:0]       cond_d;
  logic [1:0]       sh_d;
  logic [4:0]       shamt_d;
  logic [RA_W-1:0]  rd_d, ra1_d, ra2_d;
  logic [WIDTH-1:0] rd1_d, rd2_d, acc_d, ext_d;
  logic [1:0]       forward_a, forward_b;
  logic [WIDTH-1:0] result_w, alu_result_m;

  logic             busy, valid_e;
  logic             regwrite_e, memwrite_e, memtoreg_e, pcsrc_e, branch_taken_e;
  logic [RA_W-1:0]  rd_e, ra1_e, ra2_e;
  logic [WIDTH-1:0] alu_result_e, write_data_e;
  logic [3:0]       flags;

  modport master (
    output flush, valid_d, regwrite_d, memwrite_d, memtoreg_d, branch_d, alusrc_d,
           alucontrol_d, flagwrite_d, cond_d, sh_d, shamt_d, rd_d, ra1_d, ra2_d,
           rd1_d, rd2_d, acc_d, ext_d, forward_a, forward_b, result_w, alu_result_m,
    input  busy, valid_e, regwrite_e, memwrite_e, memtoreg_e, pcsrc_e, branch_taken_e,
           rd_e, ra1_e, ra2_e, alu_result_e, write_data_e, flags
  );

  modport slave (
    input  flush, valid_d, regwrite_d, memwrite_d, memtoreg_d, branch_d, alusrc_d,
           alucontrol_d, flagwrite_d, cond_d, sh_d, shamt_d, rd_d, ra1_d, ra2_d,
           rd1_d, rd2_d, acc_d, ext_d, forward_a, forward_b, result_w, alu_result_m,
    output busy, valid_e, regwrite_e, memwrite_e, memtoreg_e, pcsrc_e, branch_taken_e,
           rd_e, ra1_e, ra2_e, alu_result_e, write_data_e, flags
  );
endinterface

// File: rtl/exec_stage_mc.sv
// ARM execute stage: D->E register, forwarding, shifter, ALU, NZCV flags, condition check,
// and an iterative MUL/MLA unit that holds E and stalls upstream while it runs.
module exec_stage_mc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RA_W      = 4,
  parameter int unsigned MUL_RADIX = 2
) (
  input  logic           clk,
  input  logic           reset,
  exec_stage_mc_if.slave bus
);
  localparam int unsigned N  = WIDTH / MUL_RADIX;
  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned W1 = WIDTH + 1;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_ORR = 4'h3,
    ALU_EOR = 4'h4, ALU_BIC = 4'h5, ALU_MOV = 4'h6, ALU_MVN = 4'h7,
    ALU_ADC = 4'h8, ALU_SBC = 4'h9, ALU_MUL = 4'hA, ALU_MLA = 4'hB
  } alu_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef struct packed {
    logic             valid, regwrite, memwrite, memtoreg, branch, alusrc;
    logic [3:0]       alucontrol;
    logic [1:0]       flagwrite;
    logic [3:0]       cond;
    logic [1:0]       sh;
    logic [4:0]       shamt;
    logic [RA_W-1:0]  rd, ra1, ra2;
    logic [WIDTH-1:0] rd1, rd2, acc, ext;
  } ereg_t;

  ereg_t            e_q, e_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, macc_q, macc_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0]   op_a, fwd_b, shifted, op_b, b_in, res, pp, mul_res;
  logic [2*WIDTH-1:0] rot;
  logic [LW-1:0]      amt;
  logic [WIDTH:0]     sum;
  logic               cin, arith, known, is_mul, busy, complete, pass, commit;
  logic               n_f, z_f, c_f, v_f;

  function automatic logic [WIDTH-1:0] fwd(input logic [1:0] sel, input logic [WIDTH-1:0] r,
                                           input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] m);
    unique case (sel)
      2'b01:   return w;
      2'b10:   return m;
      default: return r;
    endcase
  endfunction

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    unique case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    op_a  = fwd(bus.forward_a, e_q.rd1, bus.result_w, bus.alu_result_m);
    fwd_b = fwd(bus.forward_b, e_q.rd2, bus.result_w, bus.alu_result_m);
    amt   = LW'(e_q.shamt);
    rot   = {fwd_b, fwd_b} >> amt;
    unique case (e_q.sh)
      2'b00:   shifted = fwd_b << amt;
      2'b01:   shifted = fwd_b >> amt;
      2'b10:   shifted = $unsigned($signed(fwd_b) >>> amt);
      default: shifted = rot[WIDTH-1:0];
    endcase
    op_b = e_q.alusrc ? e_q.ext : shifted;
  end

  // One radix step: the low MUL_RADIX multiplier bits select shifted copies of the multiplicand.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < MUL_RADIX; i++)
      if (mplier_q[i]) pp = pp + (mcand_q << i);
  end
  assign mul_res = macc_q + pp;

  always_comb begin
    arith = 1'b0;
    known = 1'b1;
    b_in  = op_b;
    cin   = 1'b0;
    res   = '0;
    unique case (e_q.alucontrol)
      ALU_ADD: arith = 1'b1;
      ALU_SUB: begin arith = 1'b1; b_in = ~op_b; cin = 1'b1; end
      ALU_ADC: begin arith = 1'b1; cin = flags_q[1]; end
      ALU_SBC: begin arith = 1'b1; b_in = ~op_b; cin = flags_q[1]; end
      ALU_AND: res = op_a & op_b;
      ALU_ORR: res = op_a | op_b;
      ALU_EOR: res = op_a ^ op_b;
      ALU_BIC: res = op_a & ~op_b;
      ALU_MOV: res = op_b;
      ALU_MVN: res = ~op_b;
      ALU_MUL, ALU_MLA: res = mul_res;
      default: known = 1'b0;
    endcase
    sum = {1'b0, op_a} + {1'b0, b_in} + W1'(cin);
    if (arith) res = sum[WIDTH-1:0];
    n_f = res[WIDTH-1];
    z_f = (res == '0);
    c_f = sum[WIDTH];
    v_f = (op_a[WIDTH-1] == b_in[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
  end

  // A valid multiply is busy from entry until its last iteration, which completes unstalled.
  assign is_mul   = (e_q.alucontrol == ALU_MUL) || (e_q.alucontrol == ALU_MLA);
  assign busy     = e_q.valid && is_mul && ((state_q == S_IDLE) || (cnt_q != CW'(N - 1)));
  assign complete = e_q.valid && !busy;
  assign pass     = cond_pass(e_q.cond, flags_q);
  assign commit   = complete && pass;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    macc_d   = macc_q;
    unique case (state_q)
      S_IDLE: if (e_q.valid && is_mul) begin
        state_d  = S_RUN;
        cnt_d    = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        macc_d   = (e_q.alucontrol == ALU_MLA) ? e_q.acc : '0;
      end
      default: begin
        macc_d   = mul_res;
        mcand_d  = mcand_q << MUL_RADIX;
        mplier_d = mplier_q >> MUL_RADIX;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (commit && known) begin
      if (e_q.flagwrite[1]) flags_d[3:2] = {n_f, z_f};
      if (e_q.flagwrite[0] && arith) flags_d[1:0] = {c_f, v_f};
    end
  end

  always_comb begin
    e_d = '{valid: bus.valid_d, regwrite: bus.regwrite_d, memwrite: bus.memwrite_d,
            memtoreg: bus.memtoreg_d, branch: bus.branch_d, alusrc: bus.alusrc_d,
            alucontrol: bus.alucontrol_d, flagwrite: bus.flagwrite_d, cond: bus.cond_d,
            sh: bus.sh_d, shamt: bus.shamt_d, rd: bus.rd_d, ra1: bus.ra1_d, ra2: bus.ra2_d,
            rd1: bus.rd1_d, rd2: bus.rd2_d, acc: bus.acc_d, ext: bus.ext_d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q      <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      macc_q   <= '0;
      flags_q  <= '0;
    end else begin
      if (bus.flush)  e_q <= '0;
      else if (!busy) e_q <= e_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      macc_q   <= macc_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy           = busy;
  assign bus.valid_e        = complete;
  assign bus.regwrite_e     = e_q.regwrite && commit;
  assign bus.memwrite_e     = e_q.memwrite && commit;
  assign bus.memtoreg_e     = e_q.memtoreg && complete;
  assign bus.pcsrc_e        = (e_q.branch || (e_q.regwrite && (e_q.rd == '1))) && commit;
  assign bus.branch_taken_e = e_q.branch && commit;
  assign bus.rd_e           = e_q.rd;
  assign bus.ra1_e          = e_q.ra1;
  assign bus.ra2_e          = e_q.ra2;
  assign bus.alu_result_e   = e_q.valid ? res : '0;
  assign bus.write_data_e   = e_q.valid ? fwd_b : '0;
  assign bus.flags          = flags_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed-vector bench for exec_stage_mc: the driver queues expected completions,
// a negedge monitor compares them whenever the stage presents valid_e.
module tb_exec_stage_mc;
  localparam int unsigned WIDTH = 32, RA_W = 4, MUL_RADIX = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  exec_stage_mc_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();
  exec_stage_mc #(.WIDTH(WIDTH), .RA_W(RA_W), .MUL_RADIX(MUL_RADIX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [3:0]  op, cond, rd;
    logic [1:0]  fw, sh, fa, fb;
    logic        rw, mw, mtr, br, alusrc;
    logic [4:0]  shamt;
    logic [31:0] a, b, ext, acc, res_w, alu_m, x_res;
    logic        x_rw, x_mw, x_pc, x_bt;
    logic [3:0]  x_flags;
    int          x_busy;
  } vec_t;

  typedef struct {
    logic [31:0] res, wd;
    logic [4:0]  ctrl;
    logic [3:0]  flags, rd;
    int          busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) bcnt = 0;
      else if (bus.busy) begin
        bcnt++;
        chk("busy_gate", {59'd0, bus.valid_e, bus.regwrite_e, bus.memwrite_e, bus.pcsrc_e,
                          bus.branch_taken_e}, 64'd0);
      end else if (bus.valid_e) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", bus.alu_result_e);
        end else begin
          e = sbq.pop_front();
          chk("result", bus.alu_result_e, e.res);
          chk("write_data", bus.write_data_e, e.wd);
          chk("ctrl", {bus.regwrite_e, bus.memwrite_e, bus.memtoreg_e, bus.pcsrc_e,
                       bus.branch_taken_e}, e.ctrl);
          chk("flags", bus.flags, e.flags);
          chk("rd_e", bus.rd_e, e.rd);
          chk("busy_cycles", bcnt, e.busy);
        end
        bcnt = 0;
      end else bcnt = 0;
    end
  end

  task automatic bubble_d();
    bus.valid_d = 0; bus.regwrite_d = 0; bus.memwrite_d = 0; bus.memtoreg_d = 0;
    bus.branch_d = 0; bus.alusrc_d = 0; bus.alucontrol_d = '0; bus.flagwrite_d = '0;
    bus.cond_d = 4'hE; bus.sh_d = '0; bus.shamt_d = '0; bus.rd_d = '0; bus.ra1_d = '0;
    bus.ra2_d = '0; bus.rd1_d = '0; bus.rd2_d = '0; bus.acc_d = '0; bus.ext_d = '0;
  endtask

  task automatic set_fwd(input vec_t v);
    bus.forward_a = v.fa; bus.forward_b = v.fb;
    bus.result_w = v.res_w; bus.alu_result_m = v.alu_m;
  endtask

  task automatic clr_fwd();
    bus.forward_a = '0; bus.forward_b = '0; bus.result_w = '0; bus.alu_result_m = '0;
  endtask

  task automatic drive_d(input vec_t v);
    bus.valid_d = 1; bus.regwrite_d = v.rw; bus.memwrite_d = v.mw; bus.memtoreg_d = v.mtr;
    bus.branch_d = v.br; bus.alusrc_d = v.alusrc; bus.alucontrol_d = v.op;
    bus.flagwrite_d = v.fw; bus.cond_d = v.cond; bus.sh_d = v.sh; bus.shamt_d = v.shamt;
    bus.rd_d = v.rd; bus.ra1_d = 4'd1; bus.ra2_d = 4'd2;
    bus.rd1_d = v.a; bus.rd2_d = v.b; bus.acc_d = v.acc; bus.ext_d = v.ext;
  endtask

  function automatic vec_t base(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] fw, input logic rw, input logic [31:0] x_res,
                                input logic [3:0] x_flags);
    vec_t v;
    v = '{op: op, cond: 4'hE, rd: 4'd3, fw: fw, sh: 2'b00, fa: 2'b00, fb: 2'b00,
          rw: rw, mw: 1'b0, mtr: 1'b0, br: 1'b0, alusrc: 1'b0, shamt: 5'd0,
          a: a, b: b, ext: 32'd0, acc: 32'd0, res_w: 32'd0, alu_m: 32'd0, x_res: x_res,
          x_rw: rw, x_mw: 1'b0, x_pc: 1'b0, x_bt: 1'b0, x_flags: x_flags, x_busy: 0};
    return v;
  endfunction

  // Issue one instruction, run it to completion, leave a bubble behind it.
  task automatic go(input vec_t v);
    exp_t e;
    int   n;
    drive_d(v);
    e.res   = v.x_res;
    e.wd    = (v.fb == 2'b01) ? v.res_w : (v.fb == 2'b10) ? v.alu_m : v.b;
    e.ctrl  = {v.x_rw, v.x_mw, v.mtr, v.x_pc, v.x_bt};
    e.flags = v.x_flags;
    e.rd    = v.rd;
    e.busy  = v.x_busy;
    sbq.push_back(e);
    @(posedge clk); #1;
    bubble_d();
    set_fwd(v);
    n = 0;
    while (bus.busy && n < 64) begin
      if (n == 3) begin
        bus.valid_d = 1; bus.regwrite_d = 1; bus.flagwrite_d = 2'b11; bus.rd1_d = 32'hDEAD;
        bus.rd2_d = 32'h77; bus.forward_a = 2'b10; bus.alu_result_m = 32'h1234;
      end
      if (n == 10) begin
        bubble_d();
        set_fwd(v);
      end
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
    clr_fwd();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    vec_t v;
    int   n;
    bus.flush = 0;
    // Reset held for two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      #1;
      bus.valid_d = 1'($urandom()); bus.regwrite_d = 1'($urandom()); bus.memwrite_d = 1;
      bus.memtoreg_d = 1; bus.branch_d = 1; bus.alusrc_d = 1'($urandom());
      bus.alucontrol_d = 4'($urandom()); bus.flagwrite_d = 2'b11; bus.cond_d = 4'hE;
      bus.sh_d = 2'($urandom()); bus.shamt_d = 5'($urandom()); bus.rd_d = 4'($urandom());
      bus.ra1_d = 4'($urandom()); bus.ra2_d = 4'($urandom()); bus.rd1_d = $urandom();
      bus.rd2_d = $urandom(); bus.acc_d = $urandom(); bus.ext_d = $urandom();
      bus.forward_a = 2'($urandom()); bus.forward_b = 2'($urandom());
      bus.result_w = $urandom(); bus.alu_result_m = $urandom(); bus.flush = 1'($urandom());
      @(negedge clk);
      chk("rst_ctrl", {57'd0, bus.busy, bus.valid_e, bus.regwrite_e, bus.memwrite_e,
                       bus.memtoreg_e, bus.pcsrc_e, bus.branch_taken_e}, 64'd0);
      chk("rst_addr", {bus.rd_e, bus.ra1_e, bus.ra2_e}, 64'd0);
      chk("rst_alu", bus.alu_result_e, 64'd0);
      chk("rst_wdata", bus.write_data_e, 64'd0);
      chk("rst_flags", bus.flags, 64'd0);
    end
    bubble_d(); clr_fwd(); bus.flush = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    go(base(4'h0, 32'd5, 32'd7, 2'b11, 1, 32'd12, 4'b0000));
    go(base(4'h1, 32'd3, 32'd3, 2'b11, 1, 32'd0, 4'b0000));
    v = base(4'h0, 32'd1, 32'd1, 2'b00, 1, 32'd2, 4'b0110); v.cond = 4'h0; go(v);
    v.cond = 4'h1; v.x_rw = 0; go(v);
    v = base(4'h0, 32'hAAAA, 32'h5555, 2'b00, 1, 32'h1C, 4'b0110);
    v.fa = 2'b10; v.alu_m = 32'h10; v.fb = 2'b01; v.res_w = 32'h3; v.shamt = 5'd2; go(v);
    v = base(4'hA, 32'hFFFF_FFFF, 32'd3, 2'b00, 1, 32'hFFFF_FFFD, 4'b0110);
    v.x_busy = 16; go(v);
    v = base(4'hB, 32'd6, 32'd7, 2'b10, 1, 32'd142, 4'b0110);
    v.acc = 32'd100; v.x_busy = 16; go(v);

    // Flush at the fifth busy cycle aborts the multiply
    drive_d(base(4'hA, 32'd2, 32'd3, 2'b11, 1, 32'd6, 4'b0010));
    @(posedge clk); #1;
    bubble_d();
    n = 0;
    while (bus.busy && n < 4) begin @(posedge clk); #1; n++; end
    chk("flush_pre_busy", bus.busy, 64'd1);
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    chk("flush_busy", bus.busy, 64'd0);
    chk("flush_valid", bus.valid_e, 64'd0);
    chk("flush_flags", bus.flags, 64'b0010);

    // Flush while idle turns the incoming instruction into a bubble
    drive_d(base(4'h0, 32'd9, 32'd9, 2'b11, 1, 32'd18, 4'b0010));
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    bubble_d();
    chk("flush_idle_valid", bus.valid_e, 64'd0);
    // A multiply that is not valid never starts
    bus.alucontrol_d = 4'hA; bus.rd1_d = 32'd5; bus.rd2_d = 32'd5;
    @(posedge clk); #1;
    bubble_d();
    chk("mul_invalid_busy", bus.busy, 64'd0);
    @(posedge clk); #1;

    go(base(4'h0, 32'd1, 32'd2, 2'b00, 1, 32'd3, 4'b0010));
    go(base(4'h9, 32'd10, 32'd3, 2'b11, 1, 32'd7, 4'b0010));
    go(base(4'h1, 32'd3, 32'd5, 2'b11, 1, 32'hFFFF_FFFE, 4'b0010));
    go(base(4'h8, 32'd1, 32'd1, 2'b00, 1, 32'd2, 4'b1000));
    go(base(4'h0, 32'h7FFF_FFFF, 32'd1, 2'b11, 1, 32'h8000_0000, 4'b1000));
    v = base(4'h0, 32'd4, 32'd4, 2'b00, 1, 32'd8, 4'b1001); v.cond = 4'hA; go(v);
    v.cond = 4'hB; v.x_rw = 0; go(v);
    v.cond = 4'hF; go(v);
    go(base(4'hC, 32'd5, 32'd5, 2'b11, 1, 32'd0, 4'b1001));
    v = base(4'h5, 32'hFF, 32'h1, 2'b11, 1, 32'hF0, 4'b1001);
    v.alusrc = 1; v.ext = 32'h0F; go(v);
    v = base(4'h4, 32'd0, 32'd1, 2'b00, 1, 32'h8000_0000, 4'b0001);
    v.sh = 2'b11; v.shamt = 5'd1; go(v);
    v = base(4'h6, 32'd0, 32'h8000_0000, 2'b00, 1, 32'hF800_0000, 4'b0001);
    v.sh = 2'b10; v.shamt = 5'd4; go(v);
    v.sh = 2'b01; v.x_res = 32'h0800_0000; go(v);
    go(base(4'h7, 32'd0, 32'd0, 2'b00, 1, 32'hFFFF_FFFF, 4'b0001));
    v = base(4'h6, 32'd0, 32'h1234, 2'b00, 1, 32'h1234, 4'b0001);
    v.sh = 2'b11; v.shamt = 5'd0; go(v);
    v = base(4'h3, 32'hF0, 32'h0F, 2'b00, 0, 32'hFF, 4'b0001);
    v.br = 1; v.x_pc = 1; v.x_bt = 1; go(v);
    v = base(4'h0, 32'd1, 32'd1, 2'b00, 1, 32'd2, 4'b0001);
    v.rd = 4'd15; v.x_pc = 1; go(v);
    v = base(4'h0, 32'h100, 32'h55, 2'b00, 0, 32'h104, 4'b0001);
    v.alusrc = 1; v.ext = 32'd4; v.mw = 1; v.x_mw = 1; go(v);
    v.mw = 0; v.x_mw = 0; v.mtr = 1; v.rw = 1; v.x_rw = 1; go(v);
    go(base(4'h2, 32'hF0, 32'h3C, 2'b00, 1, 32'h30, 4'b0001));
    v = base(4'h3, 32'd0, 32'd0, 2'b00, 0, 32'd0, 4'b0001);
    v.br = 1; v.cond = 4'h0; go(v);

    // Reset in the middle of a multiply clears everything
    drive_d(base(4'hA, 32'd7, 32'd7, 2'b11, 1, 32'd49, 4'b0001));
    @(posedge clk); #1;
    bubble_d();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mulrst_pre_busy", bus.busy, 64'd1);
    reset = 0;
    @(posedge clk); #1;
    chk("mulrst_busy", bus.busy, 64'd0);
    chk("mulrst_valid", bus.valid_e, 64'd0);
    chk("mulrst_flags", bus.flags, 64'd0);
    reset = 1;
    @(posedge clk); #1;
    go(base(4'h0, 32'd2, 32'd2, 2'b11, 1, 32'd4, 4'b0000));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
